// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path.
//   FRAME_BITS  : bits captured after the start bit (8 data, parity, stop)
//   state_e     : receiver FSM states
//   chk_e       : result of the frame check
//   frame_check : stop-bit and odd-parity check on a captured frame
package ps2_pkg;

  localparam int unsigned FRAME_BITS = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StCheck
  } state_e;

  typedef enum logic [1:0] {
    ChkOk,
    ChkParity,
    ChkFrame
  } chk_e;

  // frame[7:0] data, frame[8] parity, frame[9] stop. A bad stop bit wins over bad parity.
  function automatic chk_e frame_check(input logic [FRAME_BITS-1:0] frame);
    if (!frame[FRAME_BITS-1]) begin
      return ChkFrame;
    end
    if ((^frame[FRAME_BITS-2:0]) != 1'b1) begin
      return ChkParity;
    end
    return ChkOk;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered occupancy count and a first-word-fall-through head.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i        : write wdata_i (accepted when not full, or when full with an accepted pop)
//   wdata_i       : write data
//   pop_i         : remove head entry (ignored when empty)
//   full_o        : count == DEPTH
//   empty_o       : count == 0
//   count_o       : occupancy
//   head_o        : oldest entry (valid when not empty)
module sync_fifo #(
  parameter int unsigned  WIDTH = 8,
  parameter int unsigned  DEPTH = 8,
  localparam int unsigned PtrW  = $clog2(DEPTH),
  localparam int unsigned CntW  = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             pop_ok, push_ok;

  assign full_o  = (count_q == CntW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointer width equals log2(DEPTH), so the increment wraps modulo DEPTH.
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with glitch filter, inactivity watchdog, frame checking and a
// receive FIFO.
//   clk, reset_n     : system clock, synchronous active-low reset
//   ps2_clk/ps2_data : raw asynchronous PS/2 pins
//   samplen          : filter sample enable pulse
//   rden             : pop request; q updates on the next edge
//   clr_ovf          : clear sticky overflow
//   q                : last popped byte
//   dsr, count       : FIFO not empty / occupancy
//   overflow         : sticky, a good byte was dropped on a full FIFO
//   parity_err       : one-cycle strobe per parity-rejected frame
//   frame_err        : one-cycle strobe per bad-stop or timed-out frame
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned WDT_CYCLES = 32767
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       ps2_clk,
  input  logic                       ps2_data,
  input  logic                       samplen,
  input  logic                       rden,
  input  logic                       clr_ovf,
  output logic [7:0]                 q,
  output logic                       dsr,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       parity_err,
  output logic                       frame_err
);

  localparam int unsigned WdtW = $clog2(WDT_CYCLES + 1);

  logic [1:0]            clk_sync_q, clk_sync_d;
  logic [1:0]            data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  filt_lvl_q, filt_lvl_d;
  state_e                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [3:0]            bitcnt_q, bitcnt_d;
  logic [WdtW-1:0]       wdt_q, wdt_d;
  logic [7:0]            q_q, q_d;
  logic                  ovf_q, ovf_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;

  logic                  fall_ce;
  logic                  data_s;
  logic                  push;
  logic                  fifo_full, fifo_empty;
  logic [7:0]            fifo_head;

  assign data_s = data_sync_q[1];
  // Level is still high while the filter is all zeros only on the cycle before it drops.
  assign fall_ce = filt_lvl_q & (filter_q == '0);

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    filter_d    = filter_q;
    if (samplen) filter_d = {filter_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_lvl_d = filt_lvl_q;
    if (filter_q == '0) begin
      filt_lvl_d = 1'b0;
    end else if (filter_q == '1) begin
      filt_lvl_d = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    wdt_d    = wdt_q;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;
    push     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fall_ce && !data_s) begin
          wdt_d    = WdtW'(WDT_CYCLES);
          bitcnt_d = '0;
          state_d  = StRecv;
        end
      end
      StRecv: begin
        if (fall_ce) begin
          shift_d  = {data_s, shift_q[FRAME_BITS-1:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          wdt_d    = WdtW'(WDT_CYCLES);
          if (bitcnt_q == 4'(FRAME_BITS - 1)) state_d = StCheck;
        end else if (wdt_q == '0) begin
          ferr_d  = 1'b1;
          state_d = StIdle;
        end else begin
          wdt_d = wdt_q - WdtW'(1);
        end
      end
      StCheck: begin
        unique case (frame_check(shift_q))
          ChkFrame:  ferr_d = 1'b1;
          ChkParity: perr_d = 1'b1;
          default:   push   = 1'b1;
        endcase
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A full FIFO only drops when no pop frees a slot in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (push && fifo_full && !rden) ovf_d = 1'b1;
    q_d = q_q;
    if (rden && !fifo_empty) q_d = fifo_head;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filter_q    <= '1;
      filt_lvl_q  <= 1'b1;
      state_q     <= StIdle;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      wdt_q       <= '0;
      q_q         <= '0;
      ovf_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      filter_q    <= filter_d;
      filt_lvl_q  <= filt_lvl_d;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      wdt_q       <= wdt_d;
      q_q         <= q_d;
      ovf_q       <= ovf_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (push),
    .wdata_i (shift_q[7:0]),
    .pop_i   (rden),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count),
    .head_o  (fifo_head)
  );

  assign q          = q_q;
  assign dsr        = ~fifo_empty;
  assign overflow   = ovf_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int unsigned Depth = 8;
  localparam int unsigned CntW  = $clog2(Depth + 1);
  localparam int          Half  = 40;

  logic            clk = 1'b0;
  logic            reset_n, ps2_clk, ps2_data, samplen, rden, clr_ovf;
  logic [7:0]      q;
  logic            dsr, overflow, parity_err, frame_err;
  logic [CntW-1:0] count;

  int total = 0;
  int bad   = 0;
  int pe_cnt = 0;
  int fe_cnt = 0;

  ps2_rx_fifo #(
    .DEPTH      (Depth),
    .FILTER_LEN (4),
    .WDT_CYCLES (200)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .samplen    (samplen),
    .rden       (rden),
    .clr_ovf    (clr_ovf),
    .q          (q),
    .dsr        (dsr),
    .count      (count),
    .overflow   (overflow),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  initial begin
    samplen = 1'b0;
    forever begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        samplen = (i == 0);
      end
    end
  end

  // Strobe monitor: tasks compare count deltas.
  always @(negedge clk) begin
    if (parity_err === 1'b1) pe_cnt = pe_cnt + 1;
    if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
  end

  // Device-side frame: start, 8 data LSB-first, odd parity, stop. Data changes while clk high.
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      if (i == glitch_bit) begin
        repeat (14) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (12) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (Half - 26) @(negedge clk);
      end else begin
        repeat (Half) @(negedge clk);
      end
      ps2_clk = 1'b0;
      repeat (Half) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (Half + 10) @(negedge clk);
  endtask

  task automatic do_pop(output logic [7:0] got);
    @(negedge clk);
    rden = 1'b1;
    @(negedge clk);
    rden = 1'b0;
    got = q;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    total++; if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
    total++; if (dsr !== 1'b0) begin bad++; $display("FAIL reset_dsr got=%b exp=0", dsr); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({overflow, parity_err, frame_err} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got=%b exp=000", {overflow, parity_err, frame_err});
    end
  endtask

  task automatic test_single();
    logic [7:0] got;
    send_frame(8'h1C, 0, 0, 11, -1);
    total++; if (dsr !== 1'b1) begin bad++; $display("FAIL single_dsr got=%b exp=1", dsr); end
    total++; if (count !== CntW'(1)) begin bad++; $display("FAIL single_count got=%0d exp=1", count); end
    do_pop(got);
    total++; if (got !== 8'h1C) begin bad++; $display("FAIL single_q got=%h exp=1c", got); end
    total++; if (dsr !== 1'b0 || count !== '0) begin
      bad++; $display("FAIL single_drain got dsr=%b count=%0d exp dsr=0 count=0", dsr, count);
    end
  endtask

  task automatic test_errors();
    int pe0, fe0;
    logic [7:0] got;
    send_frame(8'h1C, 0, 0, 11, -1);
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1, 0, 11, -1);
    total++; if (pe_cnt - pe0 != 1 || fe_cnt != fe0) begin
      bad++; $display("FAIL parity_strobe got pe=%0d fe=%0d exp pe=1 fe=0", pe_cnt - pe0, fe_cnt - fe0);
    end
    total++; if (count !== CntW'(1)) begin bad++; $display("FAIL parity_count got=%0d exp=1", count); end
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 0, 1, 11, -1);
    total++; if (fe_cnt - fe0 != 1 || pe_cnt != pe0) begin
      bad++; $display("FAIL stop_strobe got fe=%0d pe=%0d exp fe=1 pe=0", fe_cnt - fe0, pe_cnt - pe0);
    end
    total++; if (count !== CntW'(1)) begin bad++; $display("FAIL stop_count got=%0d exp=1", count); end
    do_pop(got);
    total++; if (got !== 8'h1C || dsr !== 1'b0) begin
      bad++; $display("FAIL err_pop got q=%h dsr=%b exp q=1c dsr=0", got, dsr);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] got;
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 11, -1);
    total++; if (count !== CntW'(Depth)) begin bad++; $display("FAIL ovf_count got=%0d exp=%0d", count, Depth); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    for (int i = 1; i <= 8; i++) begin
      do_pop(got);
      total++; if (got !== 8'(i)) begin bad++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, got, 8'(i)); end
    end
    total++; if (dsr !== 1'b0 || count !== '0) begin
      bad++; $display("FAIL ovf_drain got dsr=%b count=%0d exp dsr=0 count=0", dsr, count);
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    @(negedge clk);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_watchdog();
    int pe0, fe0;
    logic [7:0] got;
    pe0 = pe_cnt; fe0 = fe_cnt;
    send_frame(8'hA5, 0, 0, 5, -1);
    repeat (400) @(negedge clk);
    total++; if (fe_cnt - fe0 != 1 || pe_cnt != pe0) begin
      bad++; $display("FAIL wdt_strobe got fe=%0d pe=%0d exp fe=1 pe=0", fe_cnt - fe0, pe_cnt - pe0);
    end
    total++; if (count !== '0) begin bad++; $display("FAIL wdt_count got=%0d exp=0", count); end
    send_frame(8'h5A, 0, 0, 11, -1);
    do_pop(got);
    total++; if (got !== 8'h5A || fe_cnt - fe0 != 1) begin
      bad++; $display("FAIL wdt_next got q=%h fe=%0d exp q=5a fe=1", got, fe_cnt - fe0);
    end
  endtask

  task automatic test_glitch();
    int pe0, fe0;
    logic [7:0] got;
    pe0 = pe_cnt; fe0 = fe_cnt;
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (12) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (60) @(negedge clk);
    send_frame(8'hF0, 0, 0, 11, 4);
    total++; if (pe_cnt != pe0 || fe_cnt != fe0) begin
      bad++; $display("FAIL glitch_strobes got pe=%0d fe=%0d exp 0 0", pe_cnt - pe0, fe_cnt - fe0);
    end
    total++; if (count !== CntW'(1)) begin bad++; $display("FAIL glitch_count got=%0d exp=1", count); end
    do_pop(got);
    total++; if (got !== 8'hF0) begin bad++; $display("FAIL glitch_q got=%h exp=f0", got); end
  endtask

  task automatic test_reset_midframe();
    int pe0, fe0;
    logic [7:0] got;
    send_frame(8'h11, 0, 0, 11, -1);
    send_frame(8'h22, 0, 0, 11, -1);
    send_frame(8'h33, 0, 0, 11, -1);
    do_pop(got);
    send_frame(8'h44, 0, 0, 11, -1);
    total++; if (count !== CntW'(3) || got !== 8'h11) begin
      bad++; $display("FAIL mid_pre got count=%0d q=%h exp count=3 q=11", count, got);
    end
    send_frame(8'h77, 0, 0, 4, -1);
    pe0 = pe_cnt; fe0 = fe_cnt;
    pulse_reset();
    total++; if (q !== 8'h00 || dsr !== 1'b0 || count !== '0) begin
      bad++; $display("FAIL mid_reset got q=%h dsr=%b count=%0d exp 00 0 0", q, dsr, count);
    end
    total++; if ({overflow, parity_err, frame_err} !== 3'b000) begin
      bad++; $display("FAIL mid_flags got=%b exp=000", {overflow, parity_err, frame_err});
    end
    repeat (300) @(negedge clk);
    total++; if (pe_cnt != pe0 || fe_cnt != fe0) begin
      bad++; $display("FAIL mid_nostrobe got pe=%0d fe=%0d exp 0 0", pe_cnt - pe0, fe_cnt - fe0);
    end
    send_frame(8'hE0, 0, 0, 11, -1);
    do_pop(got);
    total++; if (got !== 8'hE0 || dsr !== 1'b0) begin
      bad++; $display("FAIL mid_next got q=%h dsr=%b exp q=e0 dsr=0", got, dsr);
    end
  endtask

  // Reference: plain queue of accepted bytes, sticky drop flag, last-popped byte.
  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] exp_last, b, got;
    bit         exp_ovf;
    int         kind, npop, pe0, fe0;
    pulse_reset();
    exp_last = 8'h00;
    exp_ovf  = 1'b0;
    for (int n = 0; n < 14; n++) begin
      npop = $urandom_range(0, 2);
      for (int k = 0; k < npop; k++) begin
        do_pop(got);
        if (exp_q.size() > 0) exp_last = exp_q.pop_front();
        total++; if (got !== exp_last) begin
          bad++; $display("FAIL rnd_pop%0d got=%h exp=%h", n, got, exp_last);
        end
      end
      b    = 8'($urandom);
      kind = $urandom_range(0, 3);
      pe0  = pe_cnt; fe0 = fe_cnt;
      send_frame(b, kind == 2, kind == 3, 11, -1);
      if (kind < 2) begin
        if (exp_q.size() < Depth) exp_q.push_back(b);
        else exp_ovf = 1'b1;
      end
      total++; if (pe_cnt - pe0 != ((kind == 2) ? 1 : 0) || fe_cnt - fe0 != ((kind == 3) ? 1 : 0)) begin
        bad++; $display("FAIL rnd_strobe%0d got pe=%0d fe=%0d kind=%0d", n, pe_cnt - pe0, fe_cnt - fe0, kind);
      end
      total++; if (count !== CntW'(exp_q.size()) || dsr !== (exp_q.size() > 0)) begin
        bad++; $display("FAIL rnd_count%0d got=%0d exp=%0d", n, count, exp_q.size());
      end
      total++; if (overflow !== exp_ovf) begin
        bad++; $display("FAIL rnd_ovf%0d got=%b exp=%b", n, overflow, exp_ovf);
      end
    end
    while (exp_q.size() > 0) begin
      do_pop(got);
      exp_last = exp_q.pop_front();
      total++; if (got !== exp_last) begin
        bad++; $display("FAIL rnd_drain got=%h exp=%h", got, exp_last);
      end
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    rden     = 1'b0;
    clr_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_single();
    test_errors();
    test_overflow();
    test_watchdog();
    test_glitch();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
PS/2 device-to-host receiver for the keyboard subsystem, and the successor of the single-byte receiver. It adds several features:
- input synchronisation and a parametrised glitch filter on ps2_clk
- a per-bit inactivity watchdog
- parity and stop-bit checking with error strobes
- a DEPTH-entry receive FIFO, so scancode bursts (E0/F0 prefixes) survive slow consumer polling.

It sits between the PS/2 pins and the scancode-to-matrix translator.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..64.
FILTER_LEN, 4, consecutive agreeing samplen-qualified samples needed to change the filtered ps2_clk level; 2..8.
WDT_CYCLES, 32767, clk cycles allowed between consecutive falling edges inside a frame; must be >= 2.

Ports:
clk  in  1  system clock (24 MHz nominal)
reset_n  in  1  synchronous reset, active-low
ps2_clk  in  1  raw PS/2 clock pin (asynchronous)
ps2_data  in  1  raw PS/2 data pin (asynchronous)
samplen  in  1  filter sample enable, one-cycle pulse (nominally 1 MHz)
rden  in  1  pop request
clr_ovf  in  1  clears the sticky overflow flag
q  out  8  last popped byte
dsr  out  1  FIFO not empty
count  out  $clog2(DEPTH+1)  FIFO occupancy
overflow  out  1  sticky; set when a good byte is dropped because the FIFO is full
parity_err  out  1  one-cycle strobe per frame rejected for bad parity
frame_err  out  1  one-cycle strobe per frame rejected for stop bit == 0 or watchdog timeout

Behaviour:
Reset (reset_n == 0 at a clk edge):
- FIFO emptied
- q = 0, dsr = 0, count = 0, overflow = 0, parity_err = 0, frame_err = 0
- FSM returns to IDLE
- filter register set to all-ones; filtered clock level = 1
- reset mid-frame discards the partial frame with no error strobe

Input path:
- ps2_clk and ps2_data each pass through a 2-flop synchroniser on every clk.
- On samplen, the synchronised ps2_clk shifts into a FILTER_LEN-bit register.
- The filtered level becomes 0 only when all bits are 0, and becomes 1 only when all bits are 1; otherwise it holds.
- fall_ce is a one-clk pulse on each 1->0 transition of the filtered level.
- ps2_data is read in the same cycle as fall_ce, from the synchronised value.

FSM states: IDLE, RECV, CHECK.
- IDLE:
  - fall_ce with data == 0: load the watchdog, clear bitcnt, go to RECV.
  - fall_ce with data == 1: stray edge; stay in IDLE with no strobe.
- RECV:
  - Each fall_ce shifts data into a 10-bit register, LSB-first (8 data, parity, stop), reloads the watchdog to WDT_CYCLES and increments bitcnt.
  - After the 10th bit, go to CHECK.
  - Watchdog reaching 0 before the 10th bit: pulse frame_err and go to IDLE.
- CHECK (exactly one cycle), then IDLE:
  - stop == 0: pulse frame_err; nothing is pushed.
  - Otherwise, if XOR of the 8 data bits and the parity bit != 1: pulse parity_err; nothing is pushed.
  - Otherwise push the data byte. If the FIFO is full and no pop happens in the same cycle, set overflow and drop the byte; existing contents are unchanged.
- Watchdog: down-counter decremented every clk while in RECV; it is not active in IDLE.

FIFO / read side:
- rden with dsr == 1: q <= head entry on the next clk edge and the entry is popped. Latency is 1 clk. q holds between pops.
- rden with dsr == 0: ignored; q unchanged.
- Push and pop in the same cycle:
  - FIFO full: both happen, count unchanged, no overflow.
  - FIFO empty: the push lands and the pop is ignored.
- dsr and count update one clk after push/pop.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- overflow is cleared by clr_ovf. If a new overflow occurs in the same cycle as clr_ovf, overflow remains set.

Decomposition:
Package ps2_pkg holds:
- FRAME_BITS = 10
- the state enum (IDLE, RECV, CHECK)
- the frame-check function: odd-parity and stop check returning an ok/parity/frame code.

The storage and pointers belong in one sub-module, sync_fifo (WIDTH, DEPTH; push, pop, full, empty, count, head). The receiver FSM, filter and watchdog stay in the top module.

Test Plan:
- Frame 0x1C, correct parity 0, stop 1, at 12.5 kHz PS/2 clock with samplen every 24 clk: dsr rises 1 clk after CHECK. rden gives q = 0x1C next cycle; dsr = 0, count = 0.
- Frame 0x1C with the parity bit flipped: one parity_err pulse, dsr stays 0. Same frame with stop = 0: one frame_err pulse, FIFO unchanged.
- DEPTH=8, send 9 good frames 0x01..0x09 without reading: count = 8, overflow = 1. Popping 8 times yields 0x01..0x08. clr_ovf returns overflow to 0.
- Stop ps2_clk after 5 bits for > WDT_CYCLES clk: frame_err pulses once, FSM back in IDLE. A following 0x5A frame is received correctly.
- ps2_clk glitch low for FILTER_LEN-1 samples in IDLE and mid-frame: no fall_ce. Byte 0xF0 is received intact with no error strobes.
- reset_n = 0 for 1 clk mid-frame with 3 bytes queued: q = 0, count = 0, dsr = 0, flags 0. The next full frame 0xE0 is received correctly.
